// File: rtl/lsu_byte_master.sv
// rtl/lsu_byte_master.sv - MEM-stage load/store initiator over a byte-wide request/acknowledge port
module lsu_byte_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_load_type,
    input  logic [1:0]        req_store_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        beat_q, beat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       buf_q, buf_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    // Stores share the type register, encoded as {0, store_type}.
    function automatic logic [1:0] f_last_beat(input logic st, input logic [2:0] t);
        if (st) begin
            case (t[1:0])
                2'b00:   return 2'd3;
                2'b01:   return 2'd1;
                default: return 2'd0;
            endcase
        end else begin
            case (t)
                3'b000:         return 2'd3;
                3'b001, 3'b011: return 2'd1;
                default:        return 2'd0;
            endcase
        end
    endfunction

    function automatic logic f_illegal(input logic st, input logic [2:0] t);
        if (st) begin
            return t[1:0] == 2'b11;
        end
        return t > 3'd4;
    endfunction

    function automatic logic [31:0] f_extend(input logic [2:0] t, input logic [31:0] b);
        case (t)
            3'b000:  return b;
            3'b001:  return {{16{b[15]}}, b[15:0]};
            3'b010:  return {{24{b[7]}}, b[7:0]};
            3'b011:  return {16'h0000, b[15:0]};
            3'b100:  return {24'h000000, b[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    logic [2:0] req_type;
    logic [1:0] req_last;
    logic       req_misaligned;
    logic       req_bad;
    logic [1:0] last_q;
    logic [1:0] beat_n;

    always_comb begin
        req_type       = req_store ? {1'b0, req_store_type} : req_load_type;
        req_last       = f_last_beat(req_store, req_type);
        req_misaligned = ((req_last == 2'd3) && (req_addr[1:0] != 2'b00)) ||
                         ((req_last == 2'd1) && req_addr[0]);
        req_bad        = f_illegal(req_store, req_type) || req_misaligned;
        last_q         = f_last_beat(store_q, type_q);
        beat_n         = beat_q + 2'd1;
    end

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        type_d      = type_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        buf_d       = buf_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    type_d  = req_type;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    beat_d  = 2'd0;
                    wait_d  = '0;
                    buf_d   = 32'h0;
                    if (req_bad) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_store;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata[7:0];
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    wait_d = '0;
                    if (!store_q) begin
                        buf_d[{beat_q, 3'b000} +: 8] = mem_rdata;
                    end
                    if (beat_q == last_q) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = store_q ? 32'h0 : f_extend(type_q, buf_d);
                    end else begin
                        // Next beat is presented straight away so the port sees no bubble.
                        beat_d      = beat_n;
                        mem_req_d   = 1'b1;
                        mem_we_d    = store_q;
                        mem_addr_d  = addr_q + ADDR_W'(beat_n);
                        mem_wdata_d = wdata_q[{beat_n, 3'b000} +: 8];
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_d    = wait_q + WAIT_W'(1);
                    mem_req_d = 1'b1;
                    mem_we_d  = store_q;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            type_q      <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            beat_q      <= 2'd0;
            wait_q      <= '0;
            buf_q       <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            buf_q       <= buf_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/lsu_byte_master.md
Name: lsu_byte_master

Overview:
- MEM-stage load/store initiator for the five-stage MIPS pipeline.
- Accepts one word, halfword or byte load/store request from the pipeline and checks alignment.
- Drives a byte-wide, request/acknowledge data-memory port: one byte per beat, little-endian (lowest address = bits 7:0).
- Returns a sign- or zero-extended 32-bit load result plus an error flag; the pipeline stalls while req_ready is low.

Parameters:
- ADDR_W, 32, byte address width on both the pipeline and memory sides.
- TIMEOUT, 16, maximum cycles a beat waits for mem_ack before the transaction aborts with error (must be >= 1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present (sampled only when req_ready=1)
- req_ready  out  1  block idle, can accept a request
- req_store  in  1  1=store, 0=load
- req_load_type  in  3  000 lw, 001 lh, 010 lb, 011 lhu, 100 lbu, others illegal
- req_store_type  in  2  00 sw, 01 sh, 10 sb, 11 illegal
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, low bytes used for sh/sb
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal type or timeout (valid with rsp_valid)
- mem_req  out  1  beat request
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  beat byte address
- mem_wdata  out  8  beat write byte
- mem_ack  in  1  beat complete this cycle; mem_rdata valid now
- mem_rdata  in  8  read byte

Behaviour:
- Reset values: FSM IDLE; req_ready=1; rsp_valid, rsp_err, mem_req, mem_we=0; rsp_rdata, mem_addr, mem_wdata=0; all internal counters and buffers cleared.
- Size: 4 bytes for lw/sw; 2 bytes for lh/lhu/sh; 1 byte for lb/lbu/sb.
- Alignment: 4-byte accesses need addr[1:0]=0; 2-byte accesses need addr[0]=0.

FSM IDLE (req_ready=1):
- On req_valid, latch store flag, type, addr and wdata.
- Misaligned or illegal type -> RESP with err=1; no memory beat is issued.
- Otherwise -> ACCESS with beat=0 and wait counter=0.

FSM ACCESS (req_ready=0):
- mem_req=1; mem_we=store flag; mem_addr=base+beat (mod 2^ADDR_W).
- mem_wdata = wdata byte[beat], i.e. bits 8*beat+7 : 8*beat.
- mem_addr and mem_wdata hold stable until mem_ack.
- On mem_ack: a load captures mem_rdata into buffer byte[beat]; reset wait counter.
  - If beat = size-1 -> RESP with err=0.
  - Otherwise beat+1, and mem_req stays high for the next beat with no bubble.
- No ack: wait counter increments. When it reaches TIMEOUT-1 without ack, mem_req drops and the FSM -> RESP with err=1.
- An ack arriving in that same cycle wins; there is no timeout.

FSM RESP:
- rsp_valid=1 for exactly one cycle, then -> IDLE.
- req_ready goes high in the cycle after RESP, so there is no back-to-back accept in RESP.

Load extension:
- lw: {b3,b2,b1,b0}.
- lh: {16{b1[7]},b1,b0}; lhu: {16'b0,b1,b0}.
- lb: {24{b0[7]},b0}; lbu: {24'b0,b0}.
- Store results and any errored result: rsp_rdata=0.

Latency:
- Zero-wait memory, N-byte access: accept in cycle 0, beats in cycles 1..N, rsp_valid in cycle N+1.
- Error detected at accept: rsp_valid in cycle 1.

Boundary conditions:
- mem_ack while not in ACCESS: ignored.
- req_valid while req_ready=0: ignored; it is not queued.
- Reset mid-ACCESS: immediately IDLE and mem_req=0. A partial store is not rolled back, and no rsp_valid is issued for the aborted request.
- Outputs are registered except req_ready, which decodes directly from the FSM state.

Test Plan:
- sw addr=0x10 wdata=0xA1B2C3D4, zero-wait ack -> 4 write beats, addr 0x10..0x13, bytes D4,C3,B2,A1; rsp_valid in cycle 5, err=0, rdata=0.
- lh addr=0x22, memory returns 0x80 then 0xF3 -> rsp_rdata=0xFFFFF380. lhu at the same address -> 0x0000F380.
- lb addr=0x07, byte 0x9C -> 0xFFFFFF9C. lbu -> 0x0000009C. lw addr=0x04 with bytes 11,22,33,44 -> 0x44332211.
- lw addr=0x06 -> no mem_req ever asserted; rsp_valid in cycle 1 with err=1 and rdata=0. Same for sh addr=0x03 and store_type=11.
- TIMEOUT=4, lw with mem_ack never asserted -> mem_req high 4 cycles then drops; rsp_err=1. A second lw with ack delayed 3 cycles per beat completes with err=0.
- sw in progress, reset pulsed after beat 2 -> mem_req=0 and req_ready=1 immediately, no rsp_valid; a following sb addr=0x30 wdata=0x55 writes a single beat of 0x55.
